// File: rtl/instruction_fetch_unit_if.sv
// Decoder <-> fetch-unit control bundle: ROM port, instruction register, PC strobes and return stack.
// Optional FETCH_STACK_ERR_EN adds sticky stack overflow/underflow flags.
interface instruction_fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 13,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] rom_addr;
    logic [13:0]         rom_data;
    logic [13:0]         instr_current;
    logic                instr_rd_en;
    logic                instr_flush;
    logic                pc_incr_en;
    logic                pc_j_en;
    logic                call_en;
    logic                ret_en;
    logic [4:0]          pclath;
    logic                pcl_wr_en;
    logic [7:0]          pcl_wr_data;
    logic [PC_WIDTH-1:0] pc;
    logic [SP_W-1:0]     stack_ptr;
`ifdef FETCH_STACK_ERR_EN
    logic                stack_overflow;
    logic                stack_underflow;
`endif

    modport master (
`ifdef FETCH_STACK_ERR_EN
        input  stack_overflow, stack_underflow,
`endif
        input  rom_addr, instr_current, pc, stack_ptr,
        output rom_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
        output call_en, ret_en, pclath, pcl_wr_en, pcl_wr_data
    );

    modport slave (
`ifdef FETCH_STACK_ERR_EN
        output stack_overflow, stack_underflow,
`endif
        output rom_addr, instr_current, pc, stack_ptr,
        input  rom_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
        input  call_en, ret_en, pclath, pcl_wr_en, pcl_wr_data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program counter, circular hardware return stack and instruction register.
// Define FETCH_STACK_ERR_EN to add sticky stack overflow/underflow detection.
module instruction_fetch_unit #(
    parameter int unsigned      PC_WIDTH     = 13,
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [12:0]      RESET_VECTOR = 13'h0000,
    parameter logic [13:0]      NOP_WORD     = 14'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_fetch_unit_if.slave bus
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic [13:0]         r_ir;
    logic [SP_W-1:0]     r_sp;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_jump_tgt;
    logic [PC_WIDTH-1:0] w_pcl_tgt;
    logic [PC_WIDTH-1:0] w_push_val;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [SP_W-1:0]     w_sp_dec;
    logic [SP_W-1:0]     w_sp_next;
    logic [13:0]         w_ir_next;
    logic                w_push;
    logic                w_pop;

    assign bus.rom_addr      = r_pc;
    assign bus.pc            = r_pc;
    assign bus.instr_current = r_ir;
    assign bus.stack_ptr     = r_sp;

    // Jump target uses the instruction register value from before this edge's update.
    always_comb begin
        w_pc_inc   = r_pc + PC_WIDTH'(1);
        w_jump_tgt = PC_WIDTH'({bus.pclath[4:3], r_ir[10:0]});
        w_pcl_tgt  = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
        w_push_val = bus.pc_incr_en ? w_pc_inc : r_pc;
        w_sp_dec   = r_sp - SP_W'(1);
        w_pop      = bus.ret_en;
        w_push     = bus.call_en && !bus.ret_en;
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        if (w_pop) begin
            w_pc_next = r_stack[w_sp_dec];
            w_sp_next = w_sp_dec;
        end else if (w_push) begin
            w_pc_next = w_jump_tgt;
            w_sp_next = r_sp + SP_W'(1);
        end else if (bus.pc_j_en) begin
            w_pc_next = w_jump_tgt;
        end else if (bus.pcl_wr_en) begin
            w_pc_next = w_pcl_tgt;
        end else if (bus.pc_incr_en) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_comb begin
        w_ir_next = r_ir;
        if (bus.instr_flush) begin
            w_ir_next = NOP_WORD;
        end else if (bus.instr_rd_en) begin
            w_ir_next = bus.rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_WIDTH'(RESET_VECTOR);
            r_ir <= NOP_WORD;
            r_sp <= '0;
        end else begin
            r_pc <= w_pc_next;
            r_ir <= w_ir_next;
            r_sp <= w_sp_next;
        end
    end

    // Stack storage is not reset; contents after reset are undefined.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= w_push_val;
        end
    end

`ifdef FETCH_STACK_ERR_EN
    localparam int unsigned LIVE_W = SP_W + 1;

    logic [LIVE_W-1:0] r_live;
    logic              r_ovf;
    logic              r_udf;

    assign bus.stack_overflow  = r_ovf;
    assign bus.stack_underflow = r_udf;

    // Occupancy saturates so the flags stay meaningful while the pointer itself wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (w_pop) begin
            if (r_live == '0) begin
                r_udf <= 1'b1;
            end else begin
                r_live <= r_live - LIVE_W'(1);
            end
        end else if (w_push) begin
            if (r_live == LIVE_W'(STACK_DEPTH)) begin
                r_ovf <= 1'b1;
            end else begin
                r_live <= r_live + LIVE_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed cases then randomized strobes vs. a behavioural model.
// Build with FETCH_STACK_ERR_EN defined to also check the sticky stack flags.
module tb_instruction_fetch_unit;
    localparam int PCW   = 13;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    // Reference model state
    int m_pc, m_ir, m_sp, m_live;
    int m_stk [DEPTH];
    bit m_ovf, m_udf;

    instruction_fetch_unit_if #(.PC_WIDTH(PCW), .STACK_DEPTH(DEPTH)) bus ();

    instruction_fetch_unit #(
        .PC_WIDTH    (PCW),
        .STACK_DEPTH (DEPTH),
        .RESET_VECTOR(13'h0000),
        .NOP_WORD    (14'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.instr_rd_en = 0; bus.instr_flush = 0; bus.pc_incr_en = 0; bus.pc_j_en = 0;
        bus.call_en = 0; bus.ret_en = 0; bus.pcl_wr_en = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_sp = 0; m_live = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
        check({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(m_pc));
        check({tag, ".ir"}, 32'(bus.instr_current), 32'(m_ir));
        check({tag, ".sp"}, 32'(bus.stack_ptr), 32'(m_sp));
`ifdef FETCH_STACK_ERR_EN
        check({tag, ".ovf"}, 32'(bus.stack_overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(bus.stack_underflow), 32'(m_udf));
`endif
    endtask

    // One clock: advance the model from the current inputs, then compare just after the edge.
    task automatic tick(input string tag);
        int tgt, old_ir;
        old_ir = m_ir;
        tgt = (int'(bus.pclath) / 8) * 2048 + (old_ir % 2048);
        if (bus.instr_flush) m_ir = 0;
        else if (bus.instr_rd_en) m_ir = int'(bus.rom_data);
        if (bus.ret_en) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_pc = m_stk[m_sp];
            if (m_live == 0) m_udf = 1; else m_live--;
        end else if (bus.call_en) begin
            m_stk[m_sp] = (m_pc + (bus.pc_incr_en ? 1 : 0)) % 8192;
            m_sp = (m_sp + 1) % DEPTH;
            m_pc = tgt;
            if (m_live == DEPTH) m_ovf = 1; else m_live++;
        end else if (bus.pc_j_en) begin
            m_pc = tgt;
        end else if (bus.pcl_wr_en) begin
            m_pc = int'(bus.pclath) * 256 + int'(bus.pcl_wr_data);
        end else if (bus.pc_incr_en) begin
            m_pc = (m_pc + 1) % 8192;
        end
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic set_pc(input int v);
        bus.pclath = 5'(v / 256); bus.pcl_wr_data = 8'(v % 256); bus.pcl_wr_en = 1;
        tick("setpc");
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        idle();
        bus.rom_data = '0; bus.pclath = '0; bus.pcl_wr_data = '0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = 0;
        model_reset();
        rst_n = 0;
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        // Prefetch: rd_en + incr at q3
        bus.rom_data = 14'h3055; bus.instr_rd_en = 1; bus.pc_incr_en = 1;
        tick("prefetch");
        check("prefetch.ir_const", 32'(bus.instr_current), 32'h3055);
        check("prefetch.addr_const", 32'(bus.rom_addr), 32'h1);

        // Goto: flush + jump leaves a NOP and lands on {pclath[4:3], target}
        bus.rom_data = 14'h2805; bus.instr_rd_en = 1;
        tick("load_goto");
        bus.pclath = 5'b01000; bus.instr_flush = 1; bus.pc_j_en = 1;
        tick("goto");
        check("goto.pc_const", 32'(bus.pc), 32'h0805);

        // Call with incr pushes pc+1, then return
        bus.pclath = 0; bus.pcl_wr_data = 8'h10; bus.pcl_wr_en = 1;
        bus.rom_data = 14'h2020; bus.instr_rd_en = 1;
        tick("call_setup");
        bus.call_en = 1; bus.pc_incr_en = 1;
        tick("call");
        check("call.pc_const", 32'(bus.pc), 32'h0020);
        bus.ret_en = 1;
        tick("ret");
        check("ret.pc_const", 32'(bus.pc), 32'h0011);

        // Nine calls wrap the stack; the ninth return address overwrites slot 0
        for (int k = 1; k <= 9; k++) begin
            set_pc(k);
            bus.call_en = 1; bus.pc_incr_en = 1;
            tick("call9");
        end
        bus.ret_en = 1;
        tick("ret9");
        check("ret9.pc_const", 32'(bus.pc), 32'd10);
        check("ret9.sp_const", 32'(bus.stack_ptr), 32'd0);
`ifdef FETCH_STACK_ERR_EN
        check("ret9.ovf_const", 32'(bus.stack_overflow), 32'd1);
`endif

        // PCL write outranks increment; increment wraps at the top
        bus.pclath = 5'h03; bus.pcl_wr_data = 8'hA0; bus.pcl_wr_en = 1; bus.pc_incr_en = 1;
        tick("pclwr");
        check("pclwr.pc_const", 32'(bus.pc), 32'h03A0);
        set_pc(13'h1FFF);
        bus.pc_incr_en = 1;
        tick("wrap");
        check("wrap.pc_const", 32'(bus.pc), 32'h0);

        // Randomized strobe mix
        for (int c = 0; c < 600; c++) begin
            bus.rom_data    = 14'($urandom);
            bus.pclath      = 5'($urandom);
            bus.pcl_wr_data = 8'($urandom);
            bus.instr_flush = ($urandom_range(0, 99) < 20);
            bus.instr_rd_en = ($urandom_range(0, 99) < 50);
            bus.pc_incr_en  = ($urandom_range(0, 99) < 50);
            bus.pc_j_en     = ($urandom_range(0, 99) < 15);
            bus.call_en     = ($urandom_range(0, 99) < 12);
            bus.ret_en      = ($urandom_range(0, 99) < 12);
            bus.pcl_wr_en   = ($urandom_range(0, 99) < 10);
            tick("rand");
        end

        // Asynchronous reset mid-run, checked before any clock edge
        set_pc(13'h0123);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.pc_const", 32'(bus.pc), 32'h0);
        #2;
        rst_n = 1;
        bus.pc_incr_en = 1;
        tick("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Responder side of the decoder control interface. Owns the program counter, the 8-level hardware return stack and the instruction register that drives instr_current. It executes the decoder's instr_rd_en, instr_flush, pc_incr_en and pc_j_en strobes, plus the call/return strobes. It sits between the synchronous program ROM and the instruction decoder.

Parameters:
PC_WIDTH, 13, program counter / ROM address width
STACK_DEPTH, 8, hardware return stack entries (power of two)
RESET_VECTOR, 13'h0000, PC value after reset
NOP_WORD, 14'h0000, word loaded into the instruction register on flush or reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rom_addr  output  PC_WIDTH  program ROM address (always equals pc)
rom_data  input  14  ROM read data; synchronous read, valid 1 cycle after rom_addr changes
instr_current  output  14  instruction register to the decoder
instr_rd_en  input  1  load rom_data into the instruction register
instr_flush  input  1  load NOP_WORD into the instruction register
pc_incr_en  input  1  pc <= pc + 1
pc_j_en  input  1  jump: pc <= {pclath[4:3], instr_current[10:0]}
call_en  input  1  push pc onto stack, then jump as pc_j_en
ret_en  input  1  pop stack into pc
pclath  input  5  PCLATH register value
pcl_wr_en  input  1  ALU write to PCL
pcl_wr_data  input  8  new PCL value
pc  output  PC_WIDTH  current PC, for PCL reads
stack_ptr  output  log2(STACK_DEPTH)  next free stack slot

Behaviour:
- Reset (rst_n low, async): pc=RESET_VECTOR, instr_current=NOP_WORD, stack_ptr=0, stack contents undefined, error flags 0. Release is synchronous to the next clk edge.
- rom_addr = pc, combinational.
- Decoder holds pc stable for 4 cycles, so rom_data is valid by q3. No fetch wait state exists.
- Instruction register update, priority order:
  - instr_flush: instr_current <= NOP_WORD.
  - else instr_rd_en: instr_current <= rom_data.
  - else hold.
- PC update, one per cycle, priority order:
  - ret_en: pc <= stack[stack_ptr-1], stack_ptr <= stack_ptr-1.
  - call_en: stack[stack_ptr] <= pc + (pc_incr_en ? 1 : 0), stack_ptr <= stack_ptr+1, pc <= jump target.
  - pc_j_en: pc <= jump target.
  - pcl_wr_en: pc <= {pclath[4:0], pcl_wr_data}.
  - pc_incr_en: pc <= pc+1.
  - else hold.
- Jump target = {pclath[4:3], instr_current[10:0]}. It uses instr_current before the same-edge register update.
- pc+1 wraps 13'h1FFF -> 13'h0000.
- Stack is circular, matching silicon:
  - 9th push overwrites slot 0 and stack_ptr wraps to 0.
  - Pop at stack_ptr 0 reads slot STACK_DEPTH-1 and wraps.
- A lower-priority PC strobe asserted with a higher-priority one is ignored; it has no side effect on the stack.
- Prefetch semantics: at q3, instr_rd_en and pc_incr_en together leave instr_current = word at old pc and pc = old pc+1.
- Goto (flush + pc_j_en) leaves a NOP in the register. That NOP's q3 fetches the target word, giving the 2-instruction-cycle branch.
- instr_current and pc are registered outputs. stack_ptr is registered.

Optional Feature:
Macro FETCH_STACK_ERR_EN.
- Defined: adds outputs stack_overflow and stack_underflow, both 1-bit.
  - stack_overflow is sticky; set on a push while STACK_DEPTH entries are live.
  - stack_underflow is sticky; set on a pop while 0 entries are live.
  - A live-entry counter of log2(STACK_DEPTH)+1 bits tracks occupancy. It saturates at 0 and STACK_DEPTH.
  - Both flags clear only on reset. Wrap behaviour is unchanged.
- Not defined: ports and counter are absent; stack wraps silently.

Test Plan:
- Reset mid-run with pc=13'h0123 and rst_n low -> pc=0, instr_current=14'h0000, stack_ptr=0 immediately, without waiting for a clock edge.
- ROM[0]=14'h3055, ROM[1]=14'h0000; pulse rd_en+incr at q3 -> instr_current=14'h3055, pc=1, rom_addr=1.
- instr_current=14'h2805 (goto 5), pclath=5'b01000; flush+pc_j_en -> instr_current=14'h0000, pc=13'h0805.
- pc=13'h0010, instr_current=14'h2020, call_en+pc_incr_en -> stack[0]=13'h0011, pc=13'h0020, stack_ptr=1. Then ret_en -> pc=13'h0011, stack_ptr=0.
- Nine consecutive calls from pc=1..9, then one ret -> pc = 9th return address, stack_ptr=0. With FETCH_STACK_ERR_EN, stack_overflow=1.
- pcl_wr_en with data 8'hA0, pclath=5'h03, pc_incr_en also high -> pc=13'h03A0. pc=13'h1FFF with incr -> pc=0.
